// File: rtl/oq_stats_if.sv
// Event, snapshot and read-port bundle of the output-queue statistics engine.
// The master drives events and reads; the slave is the engine itself.
interface oq_stats_if #(
    parameter int NUM_QUEUES  = 5,
    parameter int Q_IDX_WIDTH = 3,
    parameter int CNTR_WIDTH  = 32,
    parameter int BYTES_WIDTH = 16
);
    logic [NUM_QUEUES-1:0]             pkt_stored;
    logic [BYTES_WIDTH-1:0]            bytes_stored;
    logic [NUM_QUEUES-1:0]             pkt_removed;
    logic [NUM_QUEUES*BYTES_WIDTH-1:0] bytes_removed;
    logic [NUM_QUEUES-1:0]             pkt_dropped;
    logic [BYTES_WIDTH-1:0]            bytes_dropped;
    logic                              clr_all;
    logic                              snap_req;
    logic                              snap_done;
    logic                              rd_req;
    logic [Q_IDX_WIDTH+3:0]            rd_addr;
    logic                              rd_ack;
    logic [CNTR_WIDTH-1:0]             rd_data;
    logic [NUM_QUEUES-1:0]             underflow;

    modport master (
        output pkt_stored, bytes_stored, pkt_removed, bytes_removed,
               pkt_dropped, bytes_dropped, clr_all, snap_req, rd_req, rd_addr,
        input  snap_done, rd_ack, rd_data, underflow
    );

    modport slave (
        input  pkt_stored, bytes_stored, pkt_removed, bytes_removed,
               pkt_dropped, bytes_dropped, clr_all, snap_req, rd_req, rd_addr,
        output snap_done, rd_ack, rd_data, underflow
    );
endinterface

// File: rtl/oq_stats_engine.sv
// Per-queue packet/byte statistics with occupancy, high-water mark, snapshot bank and read port.
// Define OQ_STATS_SATURATE_EN to make cumulative counters and bytes_hwm saturate instead of wrap.
module oq_stats_engine #(
    parameter int NUM_QUEUES  = 5,
    parameter int Q_IDX_WIDTH = 3,
    parameter int CNTR_WIDTH  = 32,
    parameter int BYTES_WIDTH = 16
) (
    input  logic       axi_aclk,
    input  logic       axi_resetn,
    oq_stats_if.slave  bus
);
    localparam int NUM_STATS   = 9;
    localparam int S_PKT_ST    = 0;
    localparam int S_BYTES_ST  = 1;
    localparam int S_PKT_RM    = 2;
    localparam int S_BYTES_RM  = 3;
    localparam int S_PKT_DR    = 4;
    localparam int S_BYTES_DR  = 5;
    localparam int S_PKT_INQ   = 6;
    localparam int S_BYTES_INQ = 7;
    localparam int S_HWM       = 8;

    typedef logic [CNTR_WIDTH-1:0] cntr_t;

    cntr_t                  live_reg   [NUM_QUEUES][NUM_STATS];
    cntr_t                  live_next  [NUM_QUEUES][NUM_STATS];
    cntr_t                  shadow_reg [NUM_QUEUES][NUM_STATS];
    logic [NUM_QUEUES-1:0]  underflow_reg;
    logic [NUM_QUEUES-1:0]  underflow_next;
    logic                   snap_done_reg;
    logic                   rd_ack_reg;
    cntr_t                  rd_data_reg;
    cntr_t                  rd_mux;
    logic [BYTES_WIDTH-1:0] rm_bytes [NUM_QUEUES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_QUEUES; gi++) begin : g_rm_slice
            assign rm_bytes[gi] = bus.bytes_removed[gi*BYTES_WIDTH +: BYTES_WIDTH];
        end
    endgenerate

    function automatic cntr_t cnt_add(input cntr_t a, input cntr_t b);
        logic [CNTR_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef OQ_STATS_SATURATE_EN
        if (s[CNTR_WIDTH]) return '1;
`endif
        return s[CNTR_WIDTH-1:0];
    endfunction

    always_comb begin
        cntr_t                 bs;
        cntr_t                 br;
        cntr_t                 bd;
        logic [CNTR_WIDTH+1:0] pkt_sum;
        logic [CNTR_WIDTH+1:0] byte_sum;
        underflow_next = underflow_reg;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            for (int s = 0; s < NUM_STATS; s++) live_next[q][s] = live_reg[q][s];
            bs = bus.pkt_stored[q]  ? CNTR_WIDTH'(bus.bytes_stored)  : '0;
            br = bus.pkt_removed[q] ? CNTR_WIDTH'(rm_bytes[q])       : '0;
            bd = bus.pkt_dropped[q] ? CNTR_WIDTH'(bus.bytes_dropped) : '0;

            // Two guard bits: the top one flags a result below zero.
            pkt_sum  = {2'b00, live_reg[q][S_PKT_INQ]}
                     + {{(CNTR_WIDTH+1){1'b0}}, bus.pkt_stored[q]}
                     - {{(CNTR_WIDTH+1){1'b0}}, bus.pkt_removed[q]};
            byte_sum = {2'b00, live_reg[q][S_BYTES_INQ]} + {2'b00, bs} - {2'b00, br};

            if (pkt_sum[CNTR_WIDTH+1]) begin
                live_next[q][S_PKT_INQ] = '0;
                underflow_next[q]       = 1'b1;
            end else begin
                live_next[q][S_PKT_INQ] = pkt_sum[CNTR_WIDTH-1:0];
            end
            if (byte_sum[CNTR_WIDTH+1]) begin
                live_next[q][S_BYTES_INQ] = '0;
                underflow_next[q]         = 1'b1;
            end else begin
                live_next[q][S_BYTES_INQ] = byte_sum[CNTR_WIDTH-1:0];
            end

            if (bus.clr_all) begin
                for (int s = S_PKT_ST; s <= S_BYTES_DR; s++) live_next[q][s] = '0;
                live_next[q][S_HWM] = live_next[q][S_BYTES_INQ];
                underflow_next[q]   = 1'b0;
            end else begin
                live_next[q][S_PKT_ST]   = cnt_add(live_reg[q][S_PKT_ST],
                                                   CNTR_WIDTH'(bus.pkt_stored[q]));
                live_next[q][S_BYTES_ST] = cnt_add(live_reg[q][S_BYTES_ST], bs);
                live_next[q][S_PKT_RM]   = cnt_add(live_reg[q][S_PKT_RM],
                                                   CNTR_WIDTH'(bus.pkt_removed[q]));
                live_next[q][S_BYTES_RM] = cnt_add(live_reg[q][S_BYTES_RM], br);
                live_next[q][S_PKT_DR]   = cnt_add(live_reg[q][S_PKT_DR],
                                                   CNTR_WIDTH'(bus.pkt_dropped[q]));
                live_next[q][S_BYTES_DR] = cnt_add(live_reg[q][S_BYTES_DR], bd);
                if (live_next[q][S_BYTES_INQ] > live_reg[q][S_HWM])
                    live_next[q][S_HWM] = live_next[q][S_BYTES_INQ];
            end
        end
    end

    // Unmapped stat indices and out-of-range queues fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            for (int s = 0; s < NUM_STATS; s++) begin
                if (bus.rd_addr[Q_IDX_WIDTH+3:4] == Q_IDX_WIDTH'(q) && bus.rd_addr[3:0] == 4'(s))
                    rd_mux = shadow_reg[q][s];
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                for (int s = 0; s < NUM_STATS; s++) begin
                    live_reg[q][s]   <= '0;
                    shadow_reg[q][s] <= '0;
                end
            end
            underflow_reg <= '0;
            snap_done_reg <= 1'b0;
            rd_ack_reg    <= 1'b0;
            rd_data_reg   <= '0;
        end else begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                for (int s = 0; s < NUM_STATS; s++) begin
                    live_reg[q][s] <= live_next[q][s];
                    if (bus.snap_req) shadow_reg[q][s] <= live_reg[q][s];
                end
            end
            underflow_reg <= underflow_next;
            snap_done_reg <= bus.snap_req;
            rd_ack_reg    <= bus.rd_req;
            if (bus.rd_req) rd_data_reg <= rd_mux;
        end
    end

    assign bus.snap_done = snap_done_reg;
    assign bus.rd_ack    = rd_ack_reg;
    assign bus.rd_data   = rd_data_reg;
    assign bus.underflow = underflow_reg;
endmodule

// File: tb/tb_oq_stats_engine.sv
// Directed bench for oq_stats_engine: a default instance plus an 8-bit-counter instance for wrap/saturate.
module tb_oq_stats_engine;
    localparam int NQ = 5;
    localparam int QW = 3;
    localparam int CW = 32;
    localparam int BW = 16;
`ifdef OQ_STATS_SATURATE_EN
    localparam int EXP_300 = 255;
`else
    localparam int EXP_300 = 44;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    oq_stats_if #(.NUM_QUEUES(NQ), .Q_IDX_WIDTH(QW), .CNTR_WIDTH(CW), .BYTES_WIDTH(BW)) bus ();
    oq_stats_if #(.NUM_QUEUES(NQ), .Q_IDX_WIDTH(QW), .CNTR_WIDTH(8),  .BYTES_WIDTH(8))  bus8 ();

    oq_stats_engine #(.NUM_QUEUES(NQ), .Q_IDX_WIDTH(QW), .CNTR_WIDTH(CW), .BYTES_WIDTH(BW)) dut (
        .axi_aclk   (clk),
        .axi_resetn (rst_n),
        .bus        (bus.slave)
    );

    oq_stats_engine #(.NUM_QUEUES(NQ), .Q_IDX_WIDTH(QW), .CNTR_WIDTH(8), .BYTES_WIDTH(8)) dut8 (
        .axi_aclk   (clk),
        .axi_resetn (rst_n),
        .bus        (bus8.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.pkt_stored = '0;  bus.bytes_stored = '0;
        bus.pkt_removed = '0; bus.bytes_removed = '0;
        bus.pkt_dropped = '0; bus.bytes_dropped = '0;
        bus.clr_all = 1'b0;   bus.snap_req = 1'b0;
        bus.rd_req = 1'b0;    bus.rd_addr = '0;
        bus8.pkt_stored = '0;  bus8.bytes_stored = '0;
        bus8.pkt_removed = '0; bus8.bytes_removed = '0;
        bus8.pkt_dropped = '0; bus8.bytes_dropped = '0;
        bus8.clr_all = 1'b0;   bus8.snap_req = 1'b0;
        bus8.rd_req = 1'b0;    bus8.rd_addr = '0;
    endtask

    // One-cycle event pulse on the default instance.
    task automatic pulse(input logic [NQ-1:0] st, input int sb, input logic [NQ-1:0] rm,
                         input int rq, input int rb, input logic [NQ-1:0] dr, input int db,
                         input logic clr, input logic snap);
        @(negedge clk);
        bus.pkt_stored = st;   bus.bytes_stored = BW'(sb);
        bus.pkt_removed = rm;  bus.bytes_removed = '0;
        bus.bytes_removed[rq*BW +: BW] = BW'(rb);
        bus.pkt_dropped = dr;  bus.bytes_dropped = BW'(db);
        bus.clr_all = clr;     bus.snap_req = snap;
        @(negedge clk);
        idle_inputs();
        $display("evt st=%b sb=%0d rm=%b q%0d rb=%0d dr=%b db=%0d clr=%0d snap=%0d",
                 st, sb, rm, rq, rb, dr, db, clr, snap);
    endtask

    task automatic snap();
        pulse('0, 0, '0, 0, 0, '0, 0, 1'b0, 1'b1);
        check_val("snap_done", 32'(bus.snap_done), 1);
    endtask

    task automatic rd_chk(input int q, input int s, input logic [31:0] exp);
        @(negedge clk);
        bus.rd_req = 1'b1;
        bus.rd_addr = 7'(q * 16 + s);
        @(negedge clk);
        bus.rd_req = 1'b0;
        $display("rd q=%0d s=%0d ack=%0d data=%0d", q, s, bus.rd_ack, bus.rd_data);
        check_val($sformatf("ack_q%0d_s%0d", q, s), 32'(bus.rd_ack), 1);
        check_val($sformatf("data_q%0d_s%0d", q, s), bus.rd_data, exp);
    endtask

    task automatic rd8_chk(input int q, input int s, input logic [31:0] exp);
        @(negedge clk);
        bus8.rd_req = 1'b1;
        bus8.rd_addr = 7'(q * 16 + s);
        @(negedge clk);
        bus8.rd_req = 1'b0;
        $display("rd8 q=%0d s=%0d ack=%0d data=%0d", q, s, bus8.rd_ack, bus8.rd_data);
        check_val($sformatf("ack8_q%0d_s%0d", q, s), 32'(bus8.rd_ack), 1);
        check_val($sformatf("data8_q%0d_s%0d", q, s), 32'(bus8.rd_data), exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_rd_ack", 32'(bus.rd_ack), 0);
        check_val("rst_rd_data", bus.rd_data, 0);
        check_val("rst_snap_done", 32'(bus.snap_done), 0);
        check_val("rst_underflow", 32'(bus.underflow), 0);
        rst_n = 1'b1;

        snap();
        @(negedge clk);
        check_val("snap_done_drop", 32'(bus.snap_done), 0);
        for (int q = 0; q < NQ; q++)
            for (int s = 0; s < 16; s++) rd_chk(q, s, 0);
        rd_chk(7, 0, 0);
        check_val("underflow_idle", 32'(bus.underflow), 0);

        // Queue 2: three 64 B stores, one 64 B remove
        repeat (3) pulse(5'b00100, 64, '0, 0, 0, '0, 0, 1'b0, 1'b0);
        pulse('0, 0, 5'b00100, 2, 64, '0, 0, 1'b0, 1'b0);
        snap();
        rd_chk(2, 0, 3);   rd_chk(2, 1, 192); rd_chk(2, 2, 1);   rd_chk(2, 3, 64);
        rd_chk(2, 4, 0);   rd_chk(2, 5, 0);   rd_chk(2, 6, 2);   rd_chk(2, 7, 128);
        rd_chk(2, 8, 192); rd_chk(2, 9, 0);   rd_chk(2, 15, 0);

        // Queue 1: 40 B in queue, then same-cycle 100 B store and 40 B remove
        pulse(5'b00010, 40, '0, 0, 0, '0, 0, 1'b0, 1'b0);
        pulse(5'b00010, 100, 5'b00010, 1, 40, '0, 0, 1'b0, 1'b0);
        check_val("underflow_q1", 32'(bus.underflow), 0);
        snap();
        rd_chk(1, 0, 2); rd_chk(1, 1, 140); rd_chk(1, 2, 1); rd_chk(1, 3, 40);
        rd_chk(1, 6, 1); rd_chk(1, 7, 100); rd_chk(1, 8, 100);

        // Queue 0: remove from empty queue
        pulse('0, 0, 5'b00001, 0, 10, '0, 0, 1'b0, 1'b0);
        check_val("underflow_q0_set", 32'(bus.underflow), 1);
        snap();
        rd_chk(0, 2, 1); rd_chk(0, 3, 10); rd_chk(0, 6, 0); rd_chk(0, 7, 0);
        repeat (3) @(negedge clk);
        check_val("underflow_q0_sticky", 32'(bus.underflow), 1);

        // Queue 3: five 1500 B drops, then snapshot together with clear
        repeat (5) pulse('0, 0, '0, 0, 0, 5'b01000, 1500, 1'b0, 1'b0);
        pulse('0, 0, '0, 0, 0, '0, 0, 1'b1, 1'b1);
        check_val("snap_done_clr", 32'(bus.snap_done), 1);
        check_val("underflow_cleared", 32'(bus.underflow), 0);

        // Back-to-back reads, then rd_data hold
        @(negedge clk);
        bus.rd_req = 1'b1; bus.rd_addr = 7'(3 * 16 + 4);
        @(negedge clk);
        bus.rd_addr = 7'(3 * 16 + 5);
        check_val("b2b_ack0", 32'(bus.rd_ack), 1);
        check_val("b2b_data0", bus.rd_data, 5);
        @(negedge clk);
        bus.rd_req = 1'b0;
        check_val("b2b_ack1", 32'(bus.rd_ack), 1);
        check_val("b2b_data1", bus.rd_data, 7500);
        @(negedge clk);
        check_val("hold_ack", 32'(bus.rd_ack), 0);
        check_val("hold_data", bus.rd_data, 7500);
        rd_chk(2, 0, 3);

        // Read in the snap cycle returns the old shadow value
        @(negedge clk);
        bus.snap_req = 1'b1; bus.rd_req = 1'b1; bus.rd_addr = 7'(3 * 16 + 4);
        @(negedge clk);
        bus.snap_req = 1'b0; bus.rd_req = 1'b0;
        check_val("snaprd_ack", 32'(bus.rd_ack), 1);
        check_val("snaprd_data", bus.rd_data, 5);
        check_val("snaprd_done", 32'(bus.snap_done), 1);
        rd_chk(3, 4, 0); rd_chk(3, 5, 0);
        rd_chk(2, 0, 0); rd_chk(2, 6, 2); rd_chk(2, 7, 128); rd_chk(2, 8, 128);
        rd_chk(1, 6, 1); rd_chk(1, 7, 100); rd_chk(1, 8, 100);

        // Events in the clr_all cycle: occupancy applies, cumulative discarded
        pulse(5'b10000, 50, '0, 0, 0, '0, 0, 1'b1, 1'b0);
        snap();
        rd_chk(4, 0, 0); rd_chk(4, 1, 0); rd_chk(4, 6, 1); rd_chk(4, 7, 50); rd_chk(4, 8, 50);

        // 8-bit counters: 300 single-byte stores on queue 4
        @(negedge clk);
        bus8.pkt_stored = 5'b10000; bus8.bytes_stored = 8'd1;
        repeat (300) @(negedge clk);
        bus8.pkt_stored = '0; bus8.bytes_stored = '0;
        bus8.snap_req = 1'b1;
        @(negedge clk);
        bus8.snap_req = 1'b0;
        check_val("snap8_done", 32'(bus8.snap_done), 1);
        rd8_chk(4, 0, EXP_300); rd8_chk(4, 1, EXP_300);
        rd8_chk(4, 6, 44);      rd8_chk(4, 7, 44); rd8_chk(4, 8, 255);

        // Asynchronous reset in the middle of a cycle
        pulse('0, 0, 5'b00001, 0, 10, '0, 0, 1'b0, 1'b0);
        check_val("underflow_preset", 32'(bus.underflow), 1);
        rd_chk(4, 7, 50);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_underflow", 32'(bus.underflow), 0);
        check_val("async_rd_data", bus.rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        snap();
        rd_chk(2, 0, 0); rd_chk(4, 7, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/oq_stats_engine.md
Name: oq_stats_engine

Overview:
Parametrised statistics engine for the BRAM output queues. It counts per-queue packets and bytes that are stored, removed and dropped, for NUM_QUEUES queues, with configurable counter width. Queue occupancy is tracked incrementally with an underflow guard, and a byte high-water mark is kept per queue. An atomic snapshot bank feeds an indexed, registered read port, so software reads a coherent view without a flattened register bus.

Parameters:
NUM_QUEUES, 5, number of output queues (1..16)
Q_IDX_WIDTH, 3, queue index width in rd_addr; 2**Q_IDX_WIDTH >= NUM_QUEUES
CNTR_WIDTH, 32, width of every counter and of rd_data
BYTES_WIDTH, 16, width of each per-event byte-count input

Ports:
axi_aclk  in  1  sole clock, rising edge
axi_resetn  in  1  asynchronous active-low reset
pkt_stored  in  NUM_QUEUES  1-cycle pulse per queue, packet stored
bytes_stored  in  BYTES_WIDTH  byte count for any pkt_stored bit set this cycle
pkt_removed  in  NUM_QUEUES  1-cycle pulse per queue, packet removed
bytes_removed  in  NUM_QUEUES*BYTES_WIDTH  per-queue removed byte count; queue q at [q*BYTES_WIDTH +: BYTES_WIDTH]
pkt_dropped  in  NUM_QUEUES  1-cycle pulse per queue, packet dropped
bytes_dropped  in  BYTES_WIDTH  byte count for any pkt_dropped bit set this cycle
clr_all  in  1  pulse: clear cumulative counters, high-water marks and underflow flags
snap_req  in  1  pulse: copy all live values into the shadow bank
snap_done  out  1  1-cycle pulse, the cycle after the copy
rd_req  in  1  read strobe
rd_addr  in  Q_IDX_WIDTH+4  {queue index, stat index[3:0]}
rd_ack  out  1  1-cycle pulse, one cycle after rd_req
rd_data  out  CNTR_WIDTH  shadow value; valid while rd_ack is high
underflow  out  NUM_QUEUES  sticky per-queue occupancy underflow flag

Behaviour:
- Async reset: all live counters, shadow bank, snap_done, rd_ack, rd_data and underflow go to 0.
- Per queue, the live registers are pkt_stored_c, bytes_stored_c, pkt_removed_c, bytes_removed_c, pkt_dropped_c, bytes_dropped_c, pkt_inq, bytes_inq, bytes_hwm.
- Cumulative counters: +1 or +bytes on each event pulse. Byte inputs are zero-extended to CNTR_WIDTH. Without saturation they wrap modulo 2**CNTR_WIDTH.
- Occupancy updates in a single cycle: pkt_inq += stored - removed; bytes_inq += bytes_stored - bytes_removed[q]. A simultaneous store and remove on the same queue nets out in that cycle.
- Underflow: if a remove would drive pkt_inq or bytes_inq below 0, the value clamps to 0 and underflow[q] is set. The flag stays set until clr_all or reset.
- High-water mark: if the next bytes_inq > bytes_hwm, then bytes_hwm <= next bytes_inq in the same cycle.
- clr_all:
  - Zeroes the six cumulative counters and underflow for all queues.
  - Sets bytes_hwm to that cycle's next bytes_inq.
  - Never alters pkt_inq or bytes_inq; occupancy still applies that cycle's events.
  - Cumulative events arriving in the clr_all cycle are discarded.
- snap_req: the shadow bank captures register values as they were before the edge. With snap_req and clr_all in the same cycle, the snapshot holds pre-clear values (read-and-clear semantics). snap_done pulses on the next cycle.
- Read port:
  - rd_req samples rd_addr; rd_ack and rd_data are registered one cycle later.
  - Back-to-back reads run at one per cycle.
  - rd_req in the snap_req cycle returns the old shadow value.
  - Stat index map: 0 pkt_stored, 1 bytes_stored, 2 pkt_removed, 3 bytes_removed, 4 pkt_dropped, 5 bytes_dropped, 6 pkt_inq, 7 bytes_inq, 8 bytes_hwm.
  - Stat 9..15, or queue index >= NUM_QUEUES, returns 0 with rd_ack still asserted.
- rd_data holds its last value when rd_ack is low.
- Reset asserted mid-operation: all state is cleared immediately. Event pulses are ignored while axi_resetn is low.

Optional Feature:
OQ_STATS_SATURATE_EN
- Defined: the six cumulative counters and bytes_hwm saturate at 2**CNTR_WIDTH-1 and never wrap. Occupancy is unaffected.
- Undefined: these counters wrap modulo 2**CNTR_WIDTH.

Test Plan:
- Reset, then snap_req, then read every address for queues 0..4 -> rd_ack 1 cycle after each rd_req; all rd_data 0; underflow 0.
- Queue 2: three stores of 64 bytes, one remove of 64 bytes, snap_req -> stat 0=3, 1=192, 2=1, 3=64, 6=2, 7=128, 8=192.
- Queue 1: same-cycle store (100 B) and remove (40 B) starting from bytes_inq=40 -> bytes_inq=100, pkt_inq unchanged, hwm=100, underflow[1]=0.
- Queue 0 empty, remove of 10 bytes -> pkt_inq=0, bytes_inq=0, underflow[0]=1; it stays 1 until clr_all, then reads 0.
- Queue 3: 5 drops of 1500 B, then snap_req and clr_all in the same cycle -> shadow stat 4=5, stat 5=7500; after the next snap_req, stat 4=0, stat 5=0, occupancy unchanged.
- CNTR_WIDTH=8, queue 4: 300 store pulses of 1 byte -> pkt_stored=44 without OQ_STATS_SATURATE_EN; 255 with it.
